unpack_frame_ctrl: RTL and testbench
====================================

# unpack_frame_ctrl

Frame sequencer in front of the 2-bit pixel unpacker. Consumes the raw UART byte stream, locks onto a sync byte, forwards exactly one frame's worth of packed bytes to the unpacker, and then holds off new bytes until the unpacker has drained. It snoops the unpacker's pixel handshake to generate start-of-frame, end-of-line and end-of-frame tags for the downstream vision pipeline.

## Interface
Parameters:
- width_p, 160, pixels per row; must be a multiple of 4
- height_p, 120, rows per frame
- sync_byte_p, 8'hA5, frame sync byte; consumed, never forwarded
- timeout_p, 100000, idle-cycle abort limit (used only with the timeout feature)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- data_i  in  8  byte from UART receiver
- valid_i  in  1  data_i valid
- ready_o  out  1  byte accepted when valid_i && ready_o
- packed_o  out  8  byte to unpacker
- valid_o  out  1  packed_o valid
- ready_i  in  1  unpacker ready
- pix_valid_i  in  1  unpacker output valid (snooped)
- pix_ready_i  in  1  consumer ready on unpacker output (snooped)
- sof_o  out  1  current unpacker pixel is frame pixel 0
- eol_o  out  1  current pixel is the last in its row
- eof_o  out  1  current pixel is the last in the frame
- busy_o  out  1  state != SYNC
- flush_o  out  1  one-cycle pulse; parent ORs it into the unpacker reset
- err_o  out  1  one-cycle pulse on abort

## Operation
- Constants: BYTES = width_p*height_p/4; PIXELS = width_p*height_p.
- States: SYNC, PAYLOAD, DRAIN.
- SYNC: ready_o=1, valid_o=0. Bytes are discarded. An accepted byte equal to sync_byte_p moves the block to PAYLOAD and clears all counters.
- PAYLOAD: pass-through. packed_o=data_i, valid_o=valid_i, ready_o=ready_i. Each byte fire increments byte_cnt. The fire of byte BYTES-1 moves the block to DRAIN. Sync-valued bytes inside the payload are treated as data.
- DRAIN: ready_o=0, valid_o=0. Waits for the pixel fire with eof_o=1, then returns to SYNC.
- Pixel fire = pix_valid_i && pix_ready_i, counted in any non-SYNC state.
  - col advances 0..width_p-1 and wraps.
  - row increments on the col wrap.
  - Pixel fires in SYNC are ignored (stale data).
- Tags are combinational from the counters and are qualified by pix_valid_i and busy_o:
  - sof_o = (row==0 && col==0)
  - eol_o = (col==width_p-1)
  - eof_o = eol_o && (row==height_p-1)
- Widths: byte_cnt is $clog2(BYTES+1) bits; col is $clog2(width_p); row is $clog2(height_p). No counter exceeds its terminal value.

## Timing
- Reset values: state=SYNC, all counters 0, ready_o=1, valid_o=0, sof_o=eol_o=eof_o=0, busy_o=0, flush_o=0, err_o=0.
- Byte path: zero latency, fully combinational. ready_o depends combinationally on ready_i in PAYLOAD only.
- Sync byte accepted at cycle N: busy_o=1 at cycle N+1, and the first payload byte can fire at N+1.
- Last payload byte fires at cycle N: state=DRAIN at N+1, ready_o=0 from N+1.
- eof pixel fires at cycle N: state=SYNC and busy_o=0 at N+1. A sync byte may be accepted at N+1.
- Simultaneous byte fire and pixel fire in the same cycle: both counters update independently.
- Reset during PAYLOAD or DRAIN: the next cycle is SYNC with counters cleared. flush_o is not pulsed, because reset_i already resets the unpacker.

## Configuration
- UNPACK_CTRL_TIMEOUT_EN defined:
  - An idle counter runs in PAYLOAD and DRAIN and clears on any byte fire or pixel fire.
  - On reaching timeout_p-1, the block pulses err_o and flush_o for one cycle and returns to SYNC with counters cleared.
- UNPACK_CTRL_TIMEOUT_EN undefined: no idle counter. err_o and flush_o are tied to 0, and timeout_p is unused.

## Structure
- Package unpack_ctrl_pkg holds:
  - typedef enum logic [1:0] {SYNC, PAYLOAD, DRAIN} unpack_ctrl_state_e
  - the default sync byte constant UNPACK_SYNC_BYTE = 8'hA5
- Sub-module: counter_roll (max_val_p = width_p-1) for the column counter. Its up_i is the pixel fire; the wrap is detected as col==max with a fire.
- Row counter, byte counter and idle counter are inline.

## Test plan
- Reset, then bytes 8'h00, 8'h3C with no sync -> both accepted and dropped; valid_o stays 0; busy_o stays 0.
- width_p=8, height_p=2: send 8'hA5 then 4 bytes 8'hE4 with pixel consumer always ready -> 16 pixels 0,1,2,3 repeated. sof_o on pixel 0; eol_o on pixels 7 and 15; eof_o on pixel 15; busy_o drops the next cycle.
- Same frame with ready_i toggling every other cycle and extra bytes queued after the payload -> exactly 4 bytes forwarded; ready_o=0 throughout DRAIN; the extra bytes stay pending until SYNC.
- Payload containing 8'hA5 as data -> forwarded to the unpacker, no resync.
- Reset asserted mid-PAYLOAD after 2 bytes, then a full new frame -> counters restart; tags are correct on the new frame.
- UNPACK_CTRL_TIMEOUT_EN with timeout_p=16: sync byte plus 1 payload byte, then silence -> err_o and flush_o pulse exactly 16 idle cycles later; state returns to SYNC.

Source files
------------

// File: rtl/unpack_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : unpack_ctrl_pkg
//  Purpose  : Shared types and constants for the unpacker frame sequencer.
//             Holds the sequencer state type and the default frame sync byte.
//  Revision : 1.0 - initial release
// ============================================================================
package unpack_ctrl_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    PAYLOAD = 2'd1,
    DRAIN   = 2'd2
  } unpack_ctrl_state_e;

  localparam logic [7:0] UNPACK_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/unpack_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : unpack_frame_ctrl_if
//  Purpose  : Byte stream, unpacker pixel snoop and frame tag bundle of the
//             frame sequencer. Signal suffixes are from the sequencer's view.
//  Ports    : slave  - the sequencer (unpack_frame_ctrl)
//             master - the surrounding logic (UART side, unpacker, consumer)
//  Revision : 1.0 - initial release
// ============================================================================
interface unpack_frame_ctrl_if;

  logic [7:0] data_i;       // byte from UART receiver
  logic       valid_i;      // data_i valid
  logic       ready_o;      // byte accepted when valid_i && ready_o
  logic [7:0] packed_o;     // byte to unpacker
  logic       valid_o;      // packed_o valid
  logic       ready_i;      // unpacker ready
  logic       pix_valid_i;  // unpacker output valid (snooped)
  logic       pix_ready_i;  // consumer ready on unpacker output (snooped)
  logic       sof_o;        // current pixel is frame pixel 0
  logic       eol_o;        // current pixel is last in its row
  logic       eof_o;        // current pixel is last in the frame
  logic       busy_o;       // sequencer not hunting for sync
  logic       flush_o;      // one-cycle unpacker flush pulse
  logic       err_o;        // one-cycle abort pulse

  modport slave (
    input  data_i, valid_i, ready_i, pix_valid_i, pix_ready_i,
    output ready_o, packed_o, valid_o, sof_o, eol_o, eof_o,
           busy_o, flush_o, err_o
  );

  modport master (
    output data_i, valid_i, ready_i, pix_valid_i, pix_ready_i,
    input  ready_o, packed_o, valid_o, sof_o, eol_o, eof_o,
           busy_o, flush_o, err_o
  );

endinterface
`default_nettype wire

// File: rtl/unpack_frame_ctrl_counter_roll.sv
`default_nettype none
// ============================================================================
//  Module   : counter_roll
//  Purpose  : Rolling up-counter 0..max_val_p with synchronous clear.
//  Ports    : clk_i, reset_i (sync, active-high), clr_i (sync clear),
//             up_i (advance), count_o (current value),
//             wrap_o (combinational: advancing from max_val_p this cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module counter_roll #(
  parameter  int max_val_p = 7,
  localparam int c_w       = $clog2(max_val_p + 1)
) (
  input  wire logic           clk_i,
  input  wire logic           reset_i,
  input  wire logic           clr_i,
  input  wire logic           up_i,
  output logic [c_w-1:0]      count_o,
  output logic                wrap_o
);

  localparam logic [c_w-1:0] c_max = c_w'(max_val_p);

  logic [c_w-1:0] r_count;

  assign count_o = r_count;
  assign wrap_o  = up_i && (r_count == c_max);

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      r_count <= '0;
    end else if (up_i) begin
      r_count <= wrap_o ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/unpack_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : unpack_frame_ctrl
//  Purpose  : Frame sequencer in front of the 2-bit pixel unpacker. Hunts for
//             the sync byte, forwards exactly one frame of packed bytes, then
//             blocks the byte stream until the unpacker emits the last pixel.
//             Snoops the pixel handshake to produce sof/eol/eof tags.
//  Ports    : clk_i, reset_i (sync, active-high), bus (unpack_frame_ctrl_if
//             slave modport: byte stream in/out, pixel snoop, tags, status)
//  Options  : UNPACK_CTRL_TIMEOUT_EN - idle watchdog that aborts a frame after
//             timeout_p quiet cycles (err_o/flush_o pulse). Without it
//             err_o/flush_o are tied low and timeout_p is unused.
//  Revision : 1.0 - initial release
// ============================================================================
module unpack_frame_ctrl
  import unpack_ctrl_pkg::*;
#(
  parameter int         width_p     = 160,
  parameter int         height_p    = 120,
  parameter logic [7:0] sync_byte_p = UNPACK_SYNC_BYTE,
  parameter int         timeout_p   = 100000
) (
  input  wire logic            clk_i,
  input  wire logic            reset_i,
  unpack_frame_ctrl_if.slave   bus
);

  localparam int c_bytes = width_p * height_p / 4;
  localparam int c_bcw   = $clog2(c_bytes + 1);
  localparam int c_colw  = $clog2(width_p);
  localparam int c_roww  = $clog2(height_p);

  localparam logic [c_bcw-1:0]  c_last_byte = c_bcw'(c_bytes - 1);
  localparam logic [c_colw-1:0] c_last_col  = c_colw'(width_p - 1);
  localparam logic [c_roww-1:0] c_last_row  = c_roww'(height_p - 1);

  unpack_ctrl_state_e r_state, w_state_nxt;

  logic [c_bcw-1:0]  r_byte_cnt;
  logic [c_roww-1:0] r_row;
  logic [c_colw-1:0] w_col;
  logic              w_col_wrap;
  logic              w_busy;
  logic              w_pix_fire;
  logic              w_pay_fire;
  logic              w_pix_qual;
  logic              w_eof_pos;
  logic              w_start;
  logic              w_abort;
  logic              w_clr;

  assign w_busy     = (r_state != SYNC);
  // Pixels seen while hunting belong to a dead frame and are not counted.
  assign w_pix_fire = w_busy && bus.pix_valid_i && bus.pix_ready_i;
  // Built from inputs, not ready_o, to keep the idle logic out of the
  // combinational next-state path.
  assign w_pay_fire = (r_state == PAYLOAD) && bus.valid_i && bus.ready_i;
  assign w_pix_qual = w_busy && bus.pix_valid_i;
  assign w_eof_pos  = (w_col == c_last_col) && (r_row == c_last_row);
  assign w_clr      = w_start || w_abort;

  // -------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= SYNC;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    bus.ready_o = 1'b1;
    bus.valid_o = 1'b0;
    unique case (r_state)
      SYNC: begin
        // Every byte is accepted and dropped; the sync byte itself is consumed.
        if (bus.valid_i && (bus.data_i == sync_byte_p)) begin
          w_state_nxt = PAYLOAD;
          w_start     = 1'b1;
        end
      end
      PAYLOAD: begin
        bus.ready_o = bus.ready_i;
        bus.valid_o = bus.valid_i;
        if (w_pay_fire && (r_byte_cnt == c_last_byte)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.ready_o = 1'b0;
        if (w_pix_fire && w_eof_pos) w_state_nxt = SYNC;
      end
      default: w_state_nxt = SYNC;
    endcase
    if (w_abort) w_state_nxt = SYNC;
  end

  assign bus.packed_o = bus.data_i;
  assign bus.busy_o   = w_busy;
  assign bus.sof_o    = w_pix_qual && (r_row == '0) && (w_col == '0);
  assign bus.eol_o    = w_pix_qual && (w_col == c_last_col);
  assign bus.eof_o    = w_pix_qual && w_eof_pos;

  // --------------------------------------------------------- counters
  always_ff @(posedge clk_i) begin
    if (reset_i || w_clr) begin
      r_byte_cnt <= '0;
      r_row      <= '0;
    end else begin
      if (w_pay_fire) r_byte_cnt <= r_byte_cnt + 1'b1;
      if (w_col_wrap) r_row <= (r_row == c_last_row) ? '0 : r_row + 1'b1;
    end
  end

  counter_roll #(
    .max_val_p (width_p - 1)
  ) u_col (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (w_clr),
    .up_i    (w_pix_fire),
    .count_o (w_col),
    .wrap_o  (w_col_wrap)
  );

  // ------------------------------------------------------ idle watchdog
`ifdef UNPACK_CTRL_TIMEOUT_EN
  localparam int c_idw = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [c_idw-1:0] c_idle_last = c_idw'(timeout_p - 1);

  logic [c_idw-1:0] r_idle;
  logic             w_activity;

  assign w_activity = w_pay_fire || w_pix_fire;
  // Abort on the cycle the count would pass timeout_p-1 with no activity.
  assign w_abort    = w_busy && !w_activity && (r_idle == c_idle_last);

  always_ff @(posedge clk_i) begin
    if (reset_i || !w_busy || w_activity || w_abort) r_idle <= '0;
    else                                             r_idle <= r_idle + 1'b1;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (timeout_p == 0);
  assign w_abort          = 1'b0;
`endif

  assign bus.err_o   = w_abort;
  assign bus.flush_o = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_unpack_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unpack_frame_ctrl
//  Purpose  : Self-checking bench for unpack_frame_ctrl (8x2 frame). Contains
//             a simple unpacker stand-in (4 pixels per forwarded byte) and a
//             frame-level reference model compared every cycle.
//  Options  : UNPACK_CTRL_TIMEOUT_EN - also exercises the idle abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unpack_frame_ctrl;
  import unpack_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int NB = W * H / 4;
  localparam int NP = W * H;
  localparam int TO = 16;
`ifdef UNPACK_CTRL_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unpack_frame_ctrl_if ifc ();

  unpack_frame_ctrl #(
    .width_p     (W),
    .height_p    (H),
    .sync_byte_p (UNPACK_SYNC_BYTE),
    .timeout_p   (TO)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (ifc.slave)
  );

  // stimulus controls
  logic [7:0] din = 8'h00;
  logic       vin = 1'b0;
  logic       rdy_base = 1'b1;
  logic       tgl_en = 1'b0;
  logic       tgl_ph = 1'b0;
  logic       prdy = 1'b1;
  logic       stale = 1'b0;
  int         pend = 0;      // pixels held by the unpacker stand-in
  bit         chk_en = 1'b0;

  assign ifc.data_i      = din;
  assign ifc.valid_i     = vin;
  assign ifc.ready_i     = tgl_en ? tgl_ph : rdy_base;
  assign ifc.pix_ready_i = prdy;
  assign ifc.pix_valid_i = (pend != 0) || stale;

  always @(posedge clk) tgl_ph <= ~tgl_ph;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------- reference model
  // Frame view: locked or hunting, bytes forwarded so far, index of the next
  // pixel within the frame, and quiet cycles since the last handshake.
  bit m_lock = 1'b0;
  int m_bytes = 0;
  int m_pix = 0;
  int m_idle = 0;

  always @(posedge clk) begin
    bit bf, pf, ab, was_drain;
    pf = ifc.pix_valid_i && ifc.pix_ready_i;
    if (rst) begin
      m_lock = 0; m_bytes = 0; m_pix = 0; m_idle = 0;
      pend <= 0;
    end else if (!m_lock) begin
      if (pf && pend > 0) pend <= pend - 1;
      if (ifc.valid_i && ifc.data_i == UNPACK_SYNC_BYTE) begin
        m_lock = 1; m_bytes = 0; m_pix = 0; m_idle = 0;
      end
    end else begin
      bf = ifc.valid_i && ifc.ready_i && (m_bytes < NB);
      ab = TMO && !bf && !pf && (m_idle == TO - 1);
      if (ab) begin
        m_lock = 0; m_bytes = 0; m_pix = 0; m_idle = 0;
        pend <= 0;
      end else begin
        was_drain = (m_bytes == NB);
        pend <= pend - ((pf && pend > 0) ? 1 : 0) + (bf ? 4 : 0);
        if (bf) m_bytes++;
        if (pf) begin
          if (m_pix == NP - 1) begin
            m_pix = 0;
            if (was_drain) m_lock = 0;
          end else begin
            m_pix++;
          end
        end
        m_idle = (bf || pf) ? 0 : m_idle + 1;
      end
    end
  end

  // ----------------------------------------------------- compare + monitor
  logic [7:0] fwd[$];
  int n_sof = 0, n_eol = 0, n_eof = 0, n_pix = 0;

  always @(negedge clk) begin
    bit e_rdy, e_val, pv, e_bf, e_pf, e_ab;
    if (chk_en) begin
      e_rdy = !m_lock ? 1'b1 : ((m_bytes < NB) ? ifc.ready_i : 1'b0);
      e_val = m_lock && (m_bytes < NB) && ifc.valid_i;
      pv    = m_lock && ifc.pix_valid_i;
      e_bf  = e_val && ifc.ready_i;
      e_pf  = ifc.pix_valid_i && ifc.pix_ready_i;
      e_ab  = TMO && m_lock && !e_bf && !e_pf && (m_idle == TO - 1);
      chk("ready_o", ifc.ready_o, e_rdy);
      chk("valid_o", ifc.valid_o, e_val);
      if (e_val) chk("packed_o", ifc.packed_o, ifc.data_i);
      chk("busy_o", ifc.busy_o, m_lock);
      chk("sof_o", ifc.sof_o, pv && (m_pix == 0));
      chk("eol_o", ifc.eol_o, pv && ((m_pix % W) == W - 1));
      chk("eof_o", ifc.eof_o, pv && (m_pix == NP - 1));
      chk("err_o", ifc.err_o, e_ab);
      chk("flush_o", ifc.flush_o, e_ab);
      if (ifc.valid_o && ifc.ready_i) fwd.push_back(ifc.packed_o);
      if (e_pf && ifc.busy_o) begin
        n_pix++;
        n_sof += int'(ifc.sof_o);
        n_eol += int'(ifc.eol_o);
        n_eof += int'(ifc.eof_o);
      end
    end
  end

  // ------------------------------------------------------------- tasks
  task automatic clr_stats();
    fwd.delete();
    n_sof = 0; n_eol = 0; n_eof = 0; n_pix = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    din = b;
    vin = 1'b1;
    forever begin
      @(negedge clk);
      if (ifc.ready_o) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!ifc.busy_o) break;
      n++;
      if (n > 400) begin
        chk("idle_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic frame_stats(input string tag);
    chk({tag, "_bytes"}, fwd.size(), NB);
    chk({tag, "_pix"}, n_pix, NP);
    chk({tag, "_sof"}, n_sof, 1);
    chk({tag, "_eol"}, n_eol, 2);
    chk({tag, "_eof"}, n_eof, 1);
  endtask

  // ----------------------------------------------------------- stimulus
  initial begin
    int n;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_ready", ifc.ready_o, 1);
    chk("rst_busy", ifc.busy_o, 0);
    chk("rst_valid", ifc.valid_o, 0);
    chk("rst_eof", ifc.eof_o, 0);
    @(posedge clk); #1;

    // bytes without sync are swallowed
    clr_stats();
    send(8'h00);
    send(8'h3C);
    @(negedge clk);
    chk("nosync_busy", ifc.busy_o, 0);
    chk("nosync_fwd", fwd.size(), 0);
    @(posedge clk); #1;

    // stale pixel while hunting: no tags, no counting
    stale = 1'b1;
    @(negedge clk);
    chk("stale_sof", ifc.sof_o, 0);
    @(posedge clk); #1;
    stale = 1'b0;

    // frame 1: everything ready
    clr_stats();
    send(8'hA5);
    repeat (NB) send(8'hE4);
    wait_idle();
    frame_stats("f1");
    for (int i = 0; i < NB; i++) chk("f1_data", fwd[i], 8'hE4);

    // frame 2: ready_i toggling, extra bytes queued behind the payload
    clr_stats();
    tgl_en = 1'b1;
    send(8'hA5);
    repeat (NB) send(8'hE4);
    din = 8'h11;
    vin = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (!ifc.busy_o || n > 400) break;
      chk("drain_ready", ifc.ready_o, 0);
      n++;
    end
    chk("drain_seen", n > 0, 1);
    @(posedge clk); #1;
    din = 8'h22;
    @(posedge clk); #1;
    vin = 1'b0;
    tgl_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    frame_stats("f2");

    // frame 3: sync value inside the payload is data
    clr_stats();
    send(8'hA5);
    send(8'hE4);
    send(8'hA5);
    send(8'h1B);
    send(8'hC6);
    wait_idle();
    frame_stats("f3");
    if (fwd.size() == NB) begin
      chk("f3_d0", fwd[0], 8'hE4);
      chk("f3_d1", fwd[1], 8'hA5);
      chk("f3_d2", fwd[2], 8'h1B);
      chk("f3_d3", fwd[3], 8'hC6);
    end

    // reset mid-payload, then a clean frame
    send(8'hA5);
    send(8'h11);
    send(8'h22);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", ifc.busy_o, 0);
    chk("mid_rst_ready", ifc.ready_o, 1);
    @(posedge clk); #1;
    clr_stats();
    send(8'hA5);
    repeat (NB) send(8'h1B);
    wait_idle();
    frame_stats("f4");

`ifdef UNPACK_CTRL_TIMEOUT_EN
    // idle abort: pixel consumer stalled so nothing moves after one byte
    prdy = 1'b0;
    send(8'hA5);
    send(8'h5A);
    n = 0;
    forever begin
      @(negedge clk);
      if (ifc.err_o || n > 100) break;
      n++;
    end
    chk("to_cycles", n + 1, 16);
    chk("to_flush", ifc.flush_o, 1);
    @(negedge clk);
    chk("to_busy", ifc.busy_o, 0);
    @(posedge clk); #1;
    prdy = 1'b1;
    repeat (2) @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
